// File: rtl/wait_state_ram_pkg.sv
// Shared types and constants for the wait-state RAM responder.
// Bus widths, FSM state encoding and the wait-counter preload helper.
package wait_state_ram_pkg;

  localparam int unsigned REG_BUS_W  = 32;
  localparam int unsigned BYTE_SEL_W = 4;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    WSR_IDLE = 2'd0,
    WSR_WAIT = 2'd1,
    WSR_DONE = 2'd2
  } wsr_state_e;

  // WAIT is skipped entirely when latency is zero, so the preload is only meaningful above zero.
  function automatic logic [CNT_W-1:0] wait_init(input int unsigned latency);
    return (latency == 0) ? '0 : CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/ram_byte_array.sv
// 2**ADDR_W x 32-bit storage with per-byte write enables and a registered read port.
// Contents are never reset; only the read register is.
module ram_byte_array
  import wait_state_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [BYTE_SEL_W-1:0] i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [REG_BUS_W-1:0]  i_wdata,
  input  logic                  i_re,
  input  logic                  i_rclr,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [REG_BUS_W-1:0]  o_rdata
);

  logic [REG_BUS_W-1:0] r_mem [2**ADDR_W];
  logic [REG_BUS_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    for (int unsigned b = 0; b < BYTE_SEL_W; b++) begin
      if (i_we[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  // Read register holds its value unless a read or a forced-zero read is issued.
  always_ff @(posedge i_clk) begin
    if (i_rst)       r_rdata <= '0;
    else if (i_rclr) r_rdata <= '0;
    else if (i_re)   r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wait_state_ram.sv
// CPU data-port RAM responder with programmable wait states and a one-cycle data_ready.
// Optional address range checking is enabled with `define RAM_RANGE_CHECK_EN.
module wait_state_ram
  import wait_state_ram_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2,
  parameter logic [31:0] BASE_HI = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        data_ready
`ifdef RAM_RANGE_CHECK_EN
  ,
  output logic        range_err
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT = wait_init(LATENCY);
  localparam int unsigned      HI_W     = 32 - ADDR_W - 2;

  wsr_state_e        r_state, w_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              r_we, r_oor;
  logic [ADDR_W-1:0] r_idx;
  logic [3:0]        r_sel;
  logic [31:0]       r_data;

  logic              w_oor_live, w_idle, w_accept;
  logic              w_req_we, w_req_oor, w_enter_done, w_rd;
  logic [ADDR_W-1:0] w_req_idx;
  logic [3:0]        w_wr_lanes;
  logic              w_unused;

`ifdef RAM_RANGE_CHECK_EN
  assign w_oor_live = (addr[31:ADDR_W+2] != BASE_HI[HI_W-1:0]);
  assign w_unused   = ^addr[1:0];
  assign range_err  = (r_state == WSR_DONE) && r_oor;
`else
  assign w_oor_live = 1'b0;
  assign w_unused   = ^{addr[1:0], addr[31:ADDR_W+2], BASE_HI};
`endif

  assign w_idle   = (r_state == WSR_IDLE);
  assign w_accept = w_idle && ce;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WSR_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
      r_idx   <= '0;
      r_sel   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_we   <= we;
        r_oor  <= w_oor_live;
        r_idx  <= addr[ADDR_W+1:2];
        r_sel  <= sel;
        r_data <= data_i;
      end
    end
  end

  // Abort (ce dropped) takes priority over the counter expiring.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      WSR_IDLE: begin
        if (ce) begin
          if (LATENCY == 0) begin
            w_next = WSR_DONE;
          end else begin
            w_next     = WSR_WAIT;
            w_cnt_next = CNT_INIT;
          end
        end
      end
      WSR_WAIT: begin
        if (!ce) begin
          w_next     = WSR_IDLE;
          w_cnt_next = '0;
        end else if (r_cnt == '0) begin
          w_next = WSR_DONE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      WSR_DONE: w_next = WSR_IDLE;
      default:  w_next = WSR_IDLE;
    endcase
  end

  // With zero latency the read is issued at accept, before the request is latched.
  assign w_req_we     = w_idle ? we : r_we;
  assign w_req_oor    = w_idle ? w_oor_live : r_oor;
  assign w_req_idx    = w_idle ? addr[ADDR_W+1:2] : r_idx;
  assign w_enter_done = (w_next == WSR_DONE) && (r_state != WSR_DONE);
  assign w_rd         = w_enter_done && !w_req_we;
  assign w_wr_lanes   = ((r_state == WSR_DONE) && r_we && !r_oor && !rst) ? r_sel : '0;
  assign data_ready   = (r_state == WSR_DONE);

  ram_byte_array #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_wr_lanes),
    .i_waddr (r_idx),
    .i_wdata (r_data),
    .i_re    (w_rd && !w_req_oor),
    .i_rclr  (w_rd && w_req_oor),
    .i_raddr (w_req_idx),
    .o_rdata (data_o)
  );

endmodule

// File: tb/tb_wait_state_ram.sv
// Self-checking bench for wait_state_ram: a LATENCY=2 instance (index 0) and a LATENCY=0 instance (index 1).
// Expected data comes from a word-array memory model; RAM_RANGE_CHECK_EN adds range_err checks.
module tb_wait_state_ram;

  localparam int unsigned AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce   [2];
  logic        we   [2];
  logic [31:0] addr [2];
  logic [3:0]  sel  [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        rdy  [2];
`ifdef RAM_RANGE_CHECK_EN
  logic        rerr [2];
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl [2][1024];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  wait_state_ram #(.ADDR_W(AW), .LATENCY(2), .BASE_HI(32'h0)) dut_l2 (
    .clk(clk), .rst(rst), .ce(ce[0]), .we(we[0]), .addr(addr[0]), .sel(sel[0]),
    .data_i(wdat[0]), .data_o(rdat[0]), .data_ready(rdy[0])
`ifdef RAM_RANGE_CHECK_EN
    , .range_err(rerr[0])
`endif
  );

  wait_state_ram #(.ADDR_W(AW), .LATENCY(0), .BASE_HI(32'h0)) dut_l0 (
    .clk(clk), .rst(rst), .ce(ce[1]), .we(we[1]), .addr(addr[1]), .sel(sel[1]),
    .data_i(wdat[1]), .data_o(rdat[1]), .data_ready(rdy[1])
`ifdef RAM_RANGE_CHECK_EN
    , .range_err(rerr[1])
`endif
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic bit is_oor(input logic [31:0] a);
`ifdef RAM_RANGE_CHECK_EN
    return a[31:AW+2] != '0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_read(input int k, input logic [31:0] a);
    if (is_oor(a)) return '0;
    return mdl[k][a[AW+1:2]];
  endfunction

  task automatic model_write(input int k, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    if (!is_oor(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mdl[k][a[AW+1:2]][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  // Drives one access, scrambles the request inputs after accept, drops ce on data_ready.
  // first = negedge count after the accept edge at which data_ready was seen (-1 if never).
  task automatic access(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output int first, output int pulses,
                        output logic [31:0] rd, output logic re);
    @(negedge clk);
    ce[k] = 1'b1; we[k] = w; addr[k] = a; sel[k] = s; wdat[k] = d;
    first = -1; pulses = 0; rd = '0; re = 1'b0;
    for (int c = 1; c <= lat_of(k) + 3; c++) begin
      @(negedge clk);
      if (rdy[k]) begin
        pulses++;
        if (first < 0) begin
          first = c;
          rd = rdat[k];
`ifdef RAM_RANGE_CHECK_EN
          re = rerr[k];
`endif
        end
        ce[k] = 1'b0;
      end else if (c == 1) begin
        we[k] = ~w; addr[k] = $urandom; sel[k] = 4'($urandom); wdat[k] = $urandom;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++; if (rdat[k] !== 32'h0) begin failures++; $display("FAIL reset_data_o[%0d]: got %h want 0", k, rdat[k]); end
      checks++; if (rdy[k] !== 1'b0) begin failures++; $display("FAIL reset_ready[%0d]: got %b want 0", k, rdy[k]); end
`ifdef RAM_RANGE_CHECK_EN
      checks++; if (rerr[k] !== 1'b0) begin failures++; $display("FAIL reset_range_err[%0d]: got %b want 0", k, rerr[k]); end
`endif
      last_rd[k] = '0;
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    int first, pulses; logic [31:0] rd; logic re;
    access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, first, pulses, rd, re);
    model_write(0, 32'h10, 4'hF, 32'hDEADBEEF);
    checks++; if (first !== 3 || pulses !== 1) begin failures++; $display("FAIL wr_latency: got first=%0d pulses=%0d want 3/1", first, pulses); end
    checks++; if (rd !== last_rd[0]) begin failures++; $display("FAIL wr_hold_data_o: got %h want %h", rd, last_rd[0]); end
    access(0, 1'b0, 32'h10, 4'hF, 32'h0, first, pulses, rd, re);
    checks++; if (first !== 3 || pulses !== 1) begin failures++; $display("FAIL rd_latency: got first=%0d pulses=%0d want 3/1", first, pulses); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    last_rd[0] = 32'hDEADBEEF;
  endtask

  task automatic test_byte_lanes;
    int first, pulses; logic [31:0] rd; logic re;
    access(0, 1'b1, 32'h10, 4'b0101, 32'h11223344, first, pulses, rd, re);
    model_write(0, 32'h10, 4'b0101, 32'h11223344);
    access(0, 1'b0, 32'h10, 4'hF, 32'h0, first, pulses, rd, re);
    checks++; if (rd !== 32'hDE22BE44) begin failures++; $display("FAIL lane_merge: got %h want de22be44", rd); end
    last_rd[0] = 32'hDE22BE44;
    access(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, first, pulses, rd, re);
    checks++; if (first !== 3 || pulses !== 1) begin failures++; $display("FAIL sel0_ready: got first=%0d pulses=%0d want 3/1", first, pulses); end
    checks++; if (rd !== 32'hDE22BE44) begin failures++; $display("FAIL sel0_hold: got %h want de22be44", rd); end
    access(0, 1'b0, 32'h10, 4'hF, 32'h0, first, pulses, rd, re);
    checks++; if (rd !== 32'hDE22BE44) begin failures++; $display("FAIL sel0_nochange: got %h want de22be44", rd); end
  endtask

  task automatic test_abort;
    int first, pulses, seen; logic [31:0] rd; logic re;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      ce[0] = 1'b1; we[0] = w[0]; addr[0] = 32'h10; sel[0] = 4'hF; wdat[0] = 32'h0;
      @(negedge clk);
      ce[0] = 1'b0;
      seen = 0;
      repeat (5) begin
        @(negedge clk);
        if (rdy[0]) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL abort_ready(we=%0d): got %0d pulses want 0", w, seen); end
      checks++; if (rdat[0] !== last_rd[0]) begin failures++; $display("FAIL abort_data_o(we=%0d): got %h want %h", w, rdat[0], last_rd[0]); end
    end
    access(0, 1'b0, 32'h10, 4'hF, 32'h0, first, pulses, rd, re);
    checks++; if (first !== 3 || rd !== exp_read(0, 32'h10)) begin failures++; $display("FAIL after_abort_read: got first=%0d data=%h want 3/%h", first, rd, exp_read(0, 32'h10)); end
    last_rd[0] = rd;
  endtask

  task automatic test_wrap;
    int first, pulses; logic [31:0] rd; logic re;
`ifdef RAM_RANGE_CHECK_EN
    access(0, 1'b1, 32'h0, 4'hF, 32'h0BADCAFE, first, pulses, rd, re);
    model_write(0, 32'h0, 4'hF, 32'h0BADCAFE);
    access(0, 1'b1, 32'h1000, 4'hF, 32'h12345678, first, pulses, rd, re);
    checks++; if (first !== 3 || re !== 1'b1) begin failures++; $display("FAIL oor_write: got first=%0d range_err=%b want 3/1", first, re); end
    access(0, 1'b0, 32'h0, 4'hF, 32'h0, first, pulses, rd, re);
    checks++; if (rd !== 32'h0BADCAFE || re !== 1'b0) begin failures++; $display("FAIL oor_mem0: got %h err=%b want 0badcafe/0", rd, re); end
    access(0, 1'b0, 32'h1000, 4'hF, 32'h0, first, pulses, rd, re);
    checks++; if (rd !== 32'h0 || re !== 1'b1) begin failures++; $display("FAIL oor_read: got %h err=%b want 0/1", rd, re); end
    last_rd[0] = 32'h0;
`else
    access(0, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, first, pulses, rd, re);
    model_write(0, 32'h1000, 4'hF, 32'hCAFEF00D);
    access(0, 1'b0, 32'h0, 4'hF, 32'h0, first, pulses, rd, re);
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL wrap_read: got %h want cafef00d", rd); end
    last_rd[0] = 32'hCAFEF00D;
`endif
  endtask

  task automatic test_reset_mid;
    int first, pulses, seen; logic [31:0] rd; logic re;
    @(negedge clk);
    ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; sel[0] = 4'hF; wdat[0] = 32'h55AA55AA;
    @(negedge clk);
    rst = 1'b1; ce[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rdy[0]) seen++;
    end
    checks++; if (seen !== 0 || rdat[0] !== 32'h0) begin failures++; $display("FAIL mid_reset: got pulses=%0d data_o=%h want 0/0", seen, rdat[0]); end
    last_rd[0] = '0;
    last_rd[1] = '0;
    access(0, 1'b0, 32'h10, 4'hF, 32'h0, first, pulses, rd, re);
    checks++; if (rd !== exp_read(0, 32'h10)) begin failures++; $display("FAIL mid_reset_write_dropped: got %h want %h", rd, exp_read(0, 32'h10)); end
    last_rd[0] = rd;
  endtask

  task automatic test_back_to_back;
    int first, pulses, n; logic [31:0] rd; logic re;
    logic [31:0] al [3];
    logic        exp_rdy;
    al = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) begin
      logic [31:0] d;
      d = $urandom;
      access(1, 1'b1, al[i], 4'hF, d, first, pulses, rd, re);
      model_write(1, al[i], 4'hF, d);
    end
    @(negedge clk);
    ce[1] = 1'b1; we[1] = 1'b0; addr[1] = al[0]; sel[1] = 4'hF;
    n = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp_rdy = (c == 1) || (c == 3) || (c == 5);
      checks++; if (rdy[1] !== exp_rdy) begin failures++; $display("FAIL b2b_ready@T+%0d: got %b want %b", c, rdy[1], exp_rdy); end
      if (exp_rdy) begin
        checks++; if (rdat[1] !== exp_read(1, al[n])) begin failures++; $display("FAIL b2b_data%0d: got %h want %h", n, rdat[1], exp_read(1, al[n])); end
        last_rd[1] = exp_read(1, al[n]);
        n++;
        if (n < 3) addr[1] = al[n];
        else ce[1] = 1'b0;
      end
    end
  endtask

  task automatic test_random;
    int first, pulses; logic [31:0] rd, a, d, e; logic re, w; logic [3:0] s;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        d = $urandom;
        access(k, 1'b1, 32'(i) << 2, 4'hF, d, first, pulses, rd, re);
        model_write(k, 32'(i) << 2, 4'hF, d);
      end
      for (int i = 0; i < 40; i++) begin
        w = 1'($urandom_range(0, 1));
        a = $urandom;
        a[AW+1:2] = AW'($urandom_range(0, 15));
`ifdef RAM_RANGE_CHECK_EN
        a[31:AW+2] = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(1, 255)) : 20'h0;
`endif
        s = 4'($urandom);
        d = $urandom;
        e = w ? last_rd[k] : exp_read(k, a);
        access(k, w, a, s, d, first, pulses, rd, re);
        checks++; if (first !== lat_of(k) + 1 || pulses !== 1) begin failures++; $display("FAIL rnd_timing[%0d.%0d]: got first=%0d pulses=%0d want %0d/1", k, i, first, pulses, lat_of(k) + 1); end
        checks++; if (rd !== e) begin failures++; $display("FAIL rnd_data[%0d.%0d] we=%b addr=%h: got %h want %h", k, i, w, a, rd, e); end
`ifdef RAM_RANGE_CHECK_EN
        checks++; if (re !== is_oor(a)) begin failures++; $display("FAIL rnd_range_err[%0d.%0d]: got %b want %b", k, i, re, is_oor(a)); end
`endif
        if (w) model_write(k, a, s, d);
        else last_rd[k] = e;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ce[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; sel[k] = '0; wdat[k] = '0;
    end
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_abort();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
